rng_ram_filler: RTL and testbench

Entropy-to-RAM fill stage sitting directly upstream of the AES key/block loader FSM. On a one-cycle `we_rng` request it collects 12 health-checked 32-bit words from the TRNG source. It writes them over RAM port A as 8 key words and 4 block words, then writes a seal word to the requested address and returns a one-cycle `ack_rng`. A stuck entropy source locks the block in a fail state, so no key is ever acknowledged from bad entropy.

---
 rtl/rng_ram_filler.sv | 178 +++++++++++++++++
 tb/tb_rng_ram_filler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_ram_filler.sv
// rng_ram_filler: collects 12 health-checked entropy words, writes them as
// 8 key words and 4 block words over a Wishbone port, then writes a seal
// word (the running fill count) and pulses ack_rng. A stuck source locks
// the block in FAIL until reset.
module rng_ram_filler #(
  parameter logic [8:0]  KEY_BASE_ADDR   = 9'h00,
  parameter logic [8:0]  BLOCK_BASE_ADDR = 9'h10,
  parameter int unsigned REP_LIMIT       = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_rng,
  input  logic [8:0]  addr_rng,
  output logic        ack_rng,
  input  logic        ent_valid,
  input  logic [31:0] ent_data,
  output logic        ent_ready,
  output logic        ram_cyc_a,
  output logic        ram_stb_a,
  output logic [3:0]  ram_we_a,
  output logic [8:0]  ram_addr_a,
  output logic [31:0] ram_data_in_a,
  input  logic        ram_ack_a,
  input  logic        ram_stall_a,
  output logic        busy,
  output logic        rng_err,
  output logic [31:0] fill_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WR_REQ, S_WR_ACK, S_SEAL_REQ, S_SEAL_ACK, S_ACK, S_FAIL
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  rep_q, rep_d;
  logic [31:0] prev_q, prev_d;
  logic        has_prev_q, has_prev_d;
  logic [8:0]  seal_addr_q, seal_addr_d;
  logic [31:0] fill_q, fill_d;

  logic        ack_d, ready_d, cyc_d, stb_d, busy_d, err_d;
  logic [3:0]  we_d;
  logic [8:0]  addr_d;
  logic [31:0] data_d;

  function automatic logic [8:0] word_addr(input logic [3:0] i);
    if (i < 4'd8) return KEY_BASE_ADDR + {5'd0, i};
    else          return BLOCK_BASE_ADDR + {5'd0, i - 4'd8};
  endfunction

  // Next-state and datapath updates; outputs are derived from the next state
  // so that every port can be driven straight from a flop.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rep_d       = rep_q;
    prev_d      = prev_q;
    has_prev_d  = has_prev_q;
    seal_addr_d = seal_addr_q;
    fill_d      = fill_q;

    case (state_q)
      S_IDLE: begin
        if (we_rng) begin
          seal_addr_d = addr_rng;
          idx_d       = '0;
          rep_d       = '0;
          has_prev_d  = 1'b0;
          state_d     = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (ent_valid) begin
          if (has_prev_q && (ent_data == prev_q)) begin
            rep_d = rep_q + 4'd1;
            if (rep_q == 4'(REP_LIMIT - 1)) state_d = S_FAIL;
          end else begin
            prev_d     = ent_data;
            has_prev_d = 1'b1;
            rep_d      = '0;
            state_d    = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (!ram_stall_a) state_d = S_WR_ACK;
      end
      S_WR_ACK: begin
        if (ram_ack_a) begin
          idx_d   = idx_q + 4'd1;
          state_d = (idx_q == 4'd11) ? S_SEAL_REQ : S_COLLECT;
        end
      end
      S_SEAL_REQ: begin
        if (!ram_stall_a) state_d = S_SEAL_ACK;
      end
      S_SEAL_ACK: begin
        if (ram_ack_a) begin
          fill_d  = fill_q + 32'd1;
          state_d = S_ACK;
        end
      end
      S_ACK:  state_d = S_IDLE;
      S_FAIL: state_d = S_FAIL;
      default: state_d = S_FAIL;
    endcase

    ack_d   = (state_d == S_ACK);
    ready_d = (state_d == S_COLLECT);
    busy_d  = (state_d != S_IDLE);
    err_d   = (state_d == S_FAIL);
    cyc_d   = 1'b0;
    stb_d   = 1'b0;
    we_d    = '0;
    addr_d  = '0;
    data_d  = '0;
    case (state_d)
      S_WR_REQ, S_WR_ACK: begin
        cyc_d  = 1'b1;
        stb_d  = (state_d == S_WR_REQ);
        we_d   = (state_d == S_WR_REQ) ? 4'hF : 4'h0;
        addr_d = word_addr(idx_d);
        data_d = prev_d;
      end
      S_SEAL_REQ, S_SEAL_ACK: begin
        cyc_d  = 1'b1;
        stb_d  = (state_d == S_SEAL_REQ);
        we_d   = (state_d == S_SEAL_REQ) ? 4'hF : 4'h0;
        addr_d = seal_addr_d;
        data_d = fill_d + 32'd1;
      end
      default: ;
    endcase
  end

  // State, datapath and output registers; reset drops the bus immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      rep_q         <= '0;
      prev_q        <= '0;
      has_prev_q    <= 1'b0;
      seal_addr_q   <= '0;
      fill_q        <= '0;
      ack_rng       <= 1'b0;
      ent_ready     <= 1'b0;
      ram_cyc_a     <= 1'b0;
      ram_stb_a     <= 1'b0;
      ram_we_a      <= '0;
      ram_addr_a    <= '0;
      ram_data_in_a <= '0;
      busy          <= 1'b0;
      rng_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rep_q         <= rep_d;
      prev_q        <= prev_d;
      has_prev_q    <= has_prev_d;
      seal_addr_q   <= seal_addr_d;
      fill_q        <= fill_d;
      ack_rng       <= ack_d;
      ent_ready     <= ready_d;
      ram_cyc_a     <= cyc_d;
      ram_stb_a     <= stb_d;
      ram_we_a      <= we_d;
      ram_addr_a    <= addr_d;
      ram_data_in_a <= data_d;
      busy          <= busy_d;
      rng_err       <= err_d;
    end
  end

  assign fill_count = fill_q;

endmodule

// File: tb/tb_rng_ram_filler.sv
// Bench for rng_ram_filler: entropy source model, Wishbone slave with
// programmable stall/ack delay, write log, and table-driven expected writes.
module tb_rng_ram_filler;

  logic        clk = 1'b0, rst_n = 1'b0, we_rng = 1'b0;
  logic [8:0]  addr_rng = '0;
  logic        ent_valid = 1'b0;
  logic [31:0] ent_data = '0;
  logic        ram_ack_a = 1'b0, ram_stall_a = 1'b0;
  logic        ack_rng, ent_ready, ram_cyc_a, ram_stb_a, busy, rng_err;
  logic [3:0]  ram_we_a;
  logic [8:0]  ram_addr_a;
  logic [31:0] ram_data_in_a, fill_count;

  rng_ram_filler #(.KEY_BASE_ADDR(9'h00), .BLOCK_BASE_ADDR(9'h10), .REP_LIMIT(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .we_rng(we_rng), .addr_rng(addr_rng),
    .ack_rng(ack_rng), .ent_valid(ent_valid), .ent_data(ent_data),
    .ent_ready(ent_ready), .ram_cyc_a(ram_cyc_a), .ram_stb_a(ram_stb_a),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_data_in_a(ram_data_in_a),
    .ram_ack_a(ram_ack_a), .ram_stall_a(ram_stall_a), .busy(busy),
    .rng_err(rng_err), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Entropy source: presents src_words in order, advancing on each accept.
  logic [31:0] src_words [0:15];
  int src_n = 0, src_gen = 0, seen_gen = 0, ptr = 0;
  bit take = 1'b0;
  always @(negedge clk) begin
    if (src_gen != seen_gen) begin
      seen_gen = src_gen;
      ptr = 0;
      take = 1'b0;
    end else if (take) begin
      ptr++;
    end
    ent_valid = (ptr < src_n);
    ent_data  = ent_valid ? src_words[ptr] : 32'h0;
    take = ent_valid && ent_ready && rst_n;
  end

  // Wishbone slave with write log.
  int stall_word = 99, stall_cycles = 0, ack_word = 99, ack_delay = 0;
  int wr_n = 0, stall_left = 0, ack_wait = 0, stall_viol = 0, wlog_n = 0;
  bit pending = 1'b0, req_seen = 1'b0;
  logic [8:0]  snap_addr = '0;
  logic [31:0] snap_data = '0;
  logic [8:0]  log_addr [0:255];
  logic [31:0] log_data [0:255];
  logic [3:0]  log_we   [0:255];
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0; req_seen = 1'b0; wr_n = 0;
      ram_stall_a = 1'b0; ram_ack_a = 1'b0;
    end else if (ram_cyc_a && ram_stb_a) begin
      ram_ack_a = 1'b0;
      if (!req_seen) begin
        req_seen   = 1'b1;
        stall_left = (wr_n == stall_word) ? stall_cycles : 0;
        snap_addr  = ram_addr_a;
        snap_data  = ram_data_in_a;
      end else if (ram_addr_a != snap_addr || ram_data_in_a != snap_data) begin
        stall_viol++;
      end
      if (stall_left > 0) begin
        ram_stall_a = 1'b1;
        stall_left--;
      end else begin
        ram_stall_a = 1'b0;
        if (wlog_n < 256) begin
          log_addr[wlog_n] = ram_addr_a;
          log_data[wlog_n] = ram_data_in_a;
          log_we[wlog_n]   = ram_we_a;
        end
        wlog_n++;
        ack_wait = (wr_n == ack_word) ? ack_delay : 0;
        pending  = 1'b1;
        wr_n++;
        req_seen = 1'b0;
      end
    end else if (ram_cyc_a && pending) begin
      ram_stall_a = 1'b0;
      if (ack_wait > 0) begin
        ram_ack_a = 1'b0;
        ack_wait--;
      end else begin
        ram_ack_a = 1'b1;
        pending = 1'b0;
      end
    end else begin
      ram_stall_a = 1'b0;
      ram_ack_a = 1'b0;
    end
    if (ack_rng) wr_n = 0;
  end

  int n_acks = 0, last_ack_cyc = 0, t0 = 0;
  always @(negedge clk) if (ack_rng) begin
    n_acks++;
    last_ack_cyc = cyc_cnt;
  end

  typedef struct { logic [8:0] addr; logic [31:0] data; } vec_t;
  vec_t        vt [0:12];
  logic [8:0]  key_map [0:11];
  logic [31:0] exp_words [0:11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic load_src(input int n);
    src_n = n;
    src_gen++;
  endtask

  task automatic start_fill(input logic [8:0] a);
    we_rng = 1'b1;
    addr_rng = a;
    t0 = cyc_cnt;
    tick(1);
    we_rng = 1'b0;
  endtask

  task automatic wait_ack(input int bound, output int rel);
    int start = n_acks;
    rel = -1;
    for (int i = 0; i < bound && n_acks == start; i++) tick(1);
    if (n_acks == start) begin
      nvec++; nerr++;
      $display("FAIL ack_timeout: no ack_rng within %0d cycles", bound);
    end else begin
      rel = last_ack_cyc - t0;
      tick(1);
      chk("ack_one_cycle", {31'd0, ack_rng}, 32'd0);
      chk("busy_after_ack", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic check_fill(input string tag, input int base, input logic [8:0] sa,
                            input logic [31:0] sv);
    for (int i = 0; i < 12; i++) begin
      vt[i].addr = key_map[i];
      vt[i].data = exp_words[i];
    end
    vt[12].addr = sa;
    vt[12].data = sv;
    chk({tag, "_nwrites"}, 32'(wlog_n - base), 32'd13);
    for (int i = 0; i < 13; i++) begin
      if (base + i < 256 && base + i < wlog_n) begin
        chk($sformatf("%s_w%0d_addr", tag, i), {23'd0, log_addr[base+i]}, {23'd0, vt[i].addr});
        chk($sformatf("%s_w%0d_data", tag, i), log_data[base+i], vt[i].data);
        chk($sformatf("%s_w%0d_we", tag, i), {28'd0, log_we[base+i]}, 32'hF);
      end
    end
  endtask

  initial begin
    int base, rel, acks0;
    bit found;
    for (int i = 0; i < 8; i++) key_map[i] = 9'(i);
    for (int i = 8; i < 12; i++) key_map[i] = 9'h10 + 9'(i - 8);

    do_reset();
    chk("rst_ack", {31'd0, ack_rng}, 0);
    chk("rst_ready", {31'd0, ent_ready}, 0);
    chk("rst_cyc", {31'd0, ram_cyc_a}, 0);
    chk("rst_stb", {31'd0, ram_stb_a}, 0);
    chk("rst_we", {28'd0, ram_we_a}, 0);
    chk("rst_addr", {23'd0, ram_addr_a}, 0);
    chk("rst_data", ram_data_in_a, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_err", {31'd0, rng_err}, 0);
    chk("rst_fill_count", fill_count, 0);

    // Ideal source
    for (int i = 0; i < 12; i++) begin src_words[i] = 32'(i + 1); exp_words[i] = 32'(i + 1); end
    load_src(12);
    base = wlog_n;
    start_fill(9'h1F);
    chk("ideal_busy", {31'd0, busy}, 1);
    wait_ack(200, rel);
    chk("ideal_ack_cycle", 32'(rel), 32'd39);
    check_fill("ideal", base, 9'h1F, 32'h1);
    chk("ideal_fill_count", fill_count, 32'd1);

    // Stall on word 5, ack delay on word 10
    do_reset();
    stall_word = 4; stall_cycles = 2; ack_word = 9; ack_delay = 3;
    load_src(12);
    base = wlog_n;
    start_fill(9'h1F);
    wait_ack(200, rel);
    chk("stall_ack_cycle", 32'(rel), 32'd44);
    check_fill("stall", base, 9'h1F, 32'h1);
    chk("stall_bus_stable", 32'(stall_viol), 0);
    stall_word = 99; ack_word = 99;

    // Repeat filtering: A,A,A,B,...
    do_reset();
    src_words[0] = 32'hCAFE0001; src_words[1] = 32'hCAFE0001;
    src_words[2] = 32'hCAFE0001; src_words[3] = 32'hBEEF0002;
    for (int i = 4; i < 14; i++) src_words[i] = 32'h100 + 32'(i);
    exp_words[0] = 32'hCAFE0001; exp_words[1] = 32'hBEEF0002;
    for (int i = 2; i < 12; i++) exp_words[i] = 32'h100 + 32'(i + 2);
    load_src(14);
    base = wlog_n;
    start_fill(9'h1F);
    wait_ack(200, rel);
    chk("rep_ack_cycle", 32'(rel), 32'd41);
    check_fill("rep", base, 9'h1F, 32'h1);
    chk("rep_err", {31'd0, rng_err}, 0);

    // Stuck source: A,A,A,A
    do_reset();
    for (int i = 0; i < 4; i++) src_words[i] = 32'h5A5A5A5A;
    src_words[4] = 32'h1; src_words[5] = 32'h2;
    load_src(6);
    base = wlog_n;
    acks0 = n_acks;
    start_fill(9'h1F);
    while (cyc_cnt < t0 + 6) tick(1);
    chk("stuck_err_c6", {31'd0, rng_err}, 0);
    tick(1);
    chk("stuck_err_c7", {31'd0, rng_err}, 1);
    tick(20);
    chk("stuck_nwrites", 32'(wlog_n - base), 1);
    chk("stuck_w0_addr", {23'd0, log_addr[base]}, 0);
    chk("stuck_w0_data", log_data[base], 32'h5A5A5A5A);
    chk("stuck_ready", {31'd0, ent_ready}, 0);
    chk("stuck_cyc", {31'd0, ram_cyc_a}, 0);
    chk("stuck_busy", {31'd0, busy}, 1);
    start_fill(9'h1F);
    tick(60);
    chk("stuck_nwrites_after_req", 32'(wlog_n - base), 1);
    chk("stuck_no_ack", 32'(n_acks - acks0), 0);
    chk("stuck_err_sticky", {31'd0, rng_err}, 1);

    // Back-to-back requests
    do_reset();
    for (int i = 0; i < 12; i++) begin src_words[i] = 32'(i + 1); exp_words[i] = 32'(i + 1); end
    load_src(12);
    base = wlog_n;
    start_fill(9'h1F);
    tick(10);
    we_rng = 1'b1; addr_rng = 9'h05;
    tick(1);
    we_rng = 1'b0;
    wait_ack(200, rel);
    check_fill("b2b1", base, 9'h1F, 32'h1);
    for (int i = 0; i < 12; i++) begin src_words[i] = 32'(i + 13); exp_words[i] = 32'(i + 13); end
    load_src(12);
    base = wlog_n;
    start_fill(9'h1E);
    wait_ack(200, rel);
    chk("b2b2_ack_cycle", 32'(rel), 32'd39);
    check_fill("b2b2", base, 9'h1E, 32'h2);
    chk("b2b2_fill_count", fill_count, 32'd2);

    // Reset while word 6 sits in WR_ACK
    do_reset();
    ack_word = 5; ack_delay = 5;
    for (int i = 0; i < 12; i++) src_words[i] = 32'(i + 1);
    load_src(12);
    start_fill(9'h1F);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (wr_n == 6 && ram_cyc_a && !ram_stb_a) found = 1'b1;
      else tick(1);
    end
    if (!found) begin
      nvec++; nerr++;
      $display("FAIL rst_mid_reach: word 6 WR_ACK not reached, wr_n %0d", wr_n);
    end
    chk("rst_mid_cyc_before", {31'd0, ram_cyc_a}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc_async", {31'd0, ram_cyc_a}, 0);
    chk("rst_mid_busy_async", {31'd0, busy}, 0);
    ack_word = 99;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 12; i++) begin src_words[i] = 32'(i + 101); exp_words[i] = 32'(i + 101); end
    load_src(12);
    base = wlog_n;
    start_fill(9'h1F);
    wait_ack(200, rel);
    chk("rst_mid_ack_cycle", 32'(rel), 32'd39);
    check_fill("rst_mid", base, 9'h1F, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
